// File: rtl/max7219_pkg.sv
// max7219_pkg: shared constants for the MAX7219-compatible receiver
package max7219_pkg;
  localparam int FRAME_W = 16;
  localparam logic [3:0] ADDR_NOOP = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0 = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1 = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2 = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3 = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4 = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5 = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6 = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7 = 4'h8;
  localparam logic [3:0] ADDR_DECODE = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN = 4'hC;
  localparam logic [3:0] ADDR_TEST = 4'hF;
  localparam logic [7:0] RST_DIGIT = 8'h00;
  localparam logic [7:0] RST_DECODE = 8'h00;
  localparam logic [3:0] RST_INTENSITY = 4'h0;
  localparam logic [2:0] RST_SCANLIM = 3'h0;
  localparam logic RST_SHUTDOWN = 1'b1;
  localparam logic RST_TEST = 1'b0;
endpackage

// File: rtl/max7219_rx_shift.sv
// max7219_rx_shift: serial synchronizers, edge detection and 16-bit frame shifter
module max7219_rx_shift
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ser_clk,
  input  logic               ser_din,
  input  logic               ser_load,
  output logic [FRAME_W-1:0] frame_word,
  output logic               load_ok,
  output logic               load_short
);
  localparam int CW = $clog2(FRAME_W + 1);
  logic [SYNC_STAGES-1:0] clk_s, din_s, load_s;
  logic clk_q, load_q, clk_rise, load_rise, full;
  logic [CW-1:0] cnt;
  assign clk_rise = clk_s[SYNC_STAGES-1] & ~clk_q;
  assign load_rise = load_s[SYNC_STAGES-1] & ~load_q;
  assign full = cnt == CW'(FRAME_W);
  assign load_ok = load_rise & full;
  assign load_short = load_rise & ~full;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      clk_s <= '0;
      din_s <= '0;
      load_s <= '1;
      clk_q <= 1'b0;
      load_q <= 1'b1;
      cnt <= '0;
      frame_word <= '0;
    end else begin
      clk_s <= {clk_s[SYNC_STAGES-2:0], ser_clk};
      din_s <= {din_s[SYNC_STAGES-2:0], ser_din};
      load_s <= {load_s[SYNC_STAGES-2:0], ser_load};
      clk_q <= clk_s[SYNC_STAGES-1];
      load_q <= load_s[SYNC_STAGES-1];
      if (load_rise)
        cnt <= '0;
      else if (clk_rise && !load_s[SYNC_STAGES-1]) begin
        frame_word <= {frame_word[FRAME_W-2:0], din_s[SYNC_STAGES-1]};
        cnt <= full ? cnt : cnt + CW'(1);
      end
    end
endmodule

// File: rtl/max7219_rx.sv
// max7219_rx: MAX7219-compatible serial responder with register file and PWM row scan
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ser_clk,
  input  logic       ser_din,
  input  logic       ser_load,
  output logic       frame_valid,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_short,
  output logic [7:0] reg_decode,
  output logic [3:0] reg_intensity,
  output logic [2:0] reg_scan_limit,
  output logic       reg_shutdown,
  output logic       reg_test,
  output logic [7:0] row_n,
  output logic [7:0] col
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [FRAME_W-1:0] frame_word;
  logic load_ok, load_short, wrap, pwm_on, unused_hi;
  logic [3:0] addr;
  logic [7:0] data, row_sel, row_nxt, col_nxt;
  logic [7:0] digit [8];
  logic [PW-1:0] presc;
  logic [2:0] index;
  assign addr = frame_word[11:8];
  assign data = frame_word[7:0];
  assign unused_hi = &frame_word[15:12];
  assign wrap = presc == PW'(SCAN_DIV - 1);
  assign row_sel = 8'b1 << index;
  assign pwm_on = (32'(presc) << 4) < ((32'(reg_intensity) + 32'd1) * 32'(SCAN_DIV));
  max7219_rx_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk(clk),
    .reset_n(reset_n),
    .ser_clk(ser_clk),
    .ser_din(ser_din),
    .ser_load(ser_load),
    .frame_word(frame_word),
    .load_ok(load_ok),
    .load_short(load_short)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      frame_valid <= 1'b0;
      frame_short <= 1'b0;
      frame_addr <= 4'h0;
      frame_data <= 8'h00;
      reg_decode <= RST_DECODE;
      reg_intensity <= RST_INTENSITY;
      reg_scan_limit <= RST_SCANLIM;
      reg_shutdown <= RST_SHUTDOWN;
      reg_test <= RST_TEST;
      for (int i = 0; i < 8; i++) digit[i] <= RST_DIGIT;
    end else begin
      frame_valid <= load_ok;
      frame_short <= load_short;
      if (load_ok) begin
        frame_addr <= addr;
        frame_data <= data;
        case (addr)
          ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
          ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7: digit[3'(addr - ADDR_DIGIT0)] <= data;
          ADDR_DECODE: reg_decode <= data;
          ADDR_INTENSITY: reg_intensity <= data[3:0];
          ADDR_SCANLIM: reg_scan_limit <= data[2:0];
          ADDR_SHUTDOWN: reg_shutdown <= ~data[0];
          ADDR_TEST: reg_test <= data[0];
          ADDR_NOOP: ;
          default: ;
        endcase
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      presc <= '0;
      index <= 3'd0;
    end else begin
      presc <= wrap ? '0 : presc + PW'(1);
      if (wrap) index <= (index >= reg_scan_limit) ? 3'd0 : index + 3'd1;
    end
  always_comb begin
    row_nxt = (reg_shutdown && !reg_test) ? 8'hFF : ~row_sel;
    col_nxt = reg_test ? 8'hFF : reg_shutdown ? 8'h00 : pwm_on ? digit[index] : 8'h00;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      row_n <= 8'hFF;
      col <= 8'h00;
    end else begin
      row_n <= row_nxt;
      col <= col_nxt;
    end
endmodule

// File: tb/tb_max7219_rx.sv
// tb_max7219_rx: randomized self-checking bench against a register-level reference model
module tb_max7219_rx;
  localparam int SD = 64;
  localparam int SS = 2;
  localparam int HP = 6;
  logic clk = 1'b0, reset_n = 1'b0, ser_clk = 1'b0, ser_din = 1'b0, ser_load = 1'b1;
  logic frame_valid, frame_short, reg_shutdown, reg_test;
  logic [3:0] frame_addr, reg_intensity;
  logic [7:0] frame_data, reg_decode, row_n, col;
  logic [2:0] reg_scan_limit;
  int tests = 0, fails = 0;
  logic [7:0] m_digit [8];
  logic [7:0] m_decode, m_data;
  logic [3:0] m_int, m_addr;
  logic [2:0] m_lim;
  logic m_shut, m_test;
  max7219_rx #(.SCAN_DIV(SD), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ser_clk(ser_clk),
    .ser_din(ser_din),
    .ser_load(ser_load),
    .frame_valid(frame_valid),
    .frame_addr(frame_addr),
    .frame_data(frame_data),
    .frame_short(frame_short),
    .reg_decode(reg_decode),
    .reg_intensity(reg_intensity),
    .reg_scan_limit(reg_scan_limit),
    .reg_shutdown(reg_shutdown),
    .reg_test(reg_test),
    .row_n(row_n),
    .col(col)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
    m_decode = 8'h00;
    m_int = 4'h0;
    m_lim = 3'h0;
    m_shut = 1'b1;
    m_test = 1'b0;
    m_addr = 4'h0;
    m_data = 8'h00;
  endtask
  task automatic model_write(input logic [15:0] w);
    int a;
    a = int'(w[11:8]);
    m_addr = w[11:8];
    m_data = w[7:0];
    if (a >= 1 && a <= 8) m_digit[a-1] = w[7:0];
    if (a == 9) m_decode = w[7:0];
    if (a == 10) m_int = w[3:0];
    if (a == 11) m_lim = w[2:0];
    if (a == 12) m_shut = ~w[0];
    if (a == 15) m_test = w[0];
  endtask
  task automatic shift_bits(input logic [31:0] w, input int n);
    ser_load = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      ser_din = w[i];
      repeat (HP) @(negedge clk);
      ser_clk = 1'b1;
      repeat (HP) @(negedge clk);
      ser_clk = 1'b0;
    end
    repeat (HP) @(negedge clk);
  endtask
  task automatic latch(input logic [31:0] w, input int n);
    int lv, ls, nv, ns;
    logic [3:0] va;
    logic [7:0] vd;
    lv = -1; ls = -1; nv = 0; ns = 0; va = 4'h0; vd = 8'h00;
    @(negedge clk);
    ser_load = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (frame_valid) begin
        nv++;
        if (lv < 0) begin lv = k; va = frame_addr; vd = frame_data; end
      end
      if (frame_short) begin
        ns++;
        if (ls < 0) ls = k;
      end
    end
    tests++;
    if (n >= 16 ? (nv != 1 || ns != 0 || lv != SS + 1) : (ns != 1 || nv != 0 || ls != SS + 1)) begin
      fails++;
      $display("FAIL latch n=%0d w=%h: valid %0d pulses first@%0d, short %0d pulses first@%0d, required one %s pulse at cycle %0d",
               n, w, nv, lv, ns, ls, n >= 16 ? "valid" : "short", SS + 1);
    end
    if (n >= 16) begin
      model_write(w[15:0]);
      tests++;
      if (va !== w[11:8] || vd !== w[7:0]) begin
        fails++;
        $display("FAIL latch_frame w=%h: addr/data at pulse %h/%h, required %h/%h", w, va, vd, w[11:8], w[7:0]);
      end
    end
    tests++;
    if ({reg_decode, reg_intensity, reg_scan_limit, reg_shutdown, reg_test, frame_addr, frame_data} !==
        {m_decode, m_int, m_lim, m_shut, m_test, m_addr, m_data}) begin
      fails++;
      $display("FAIL regs after w=%h n=%0d: dec %h int %h lim %h sd %b tst %b fa %h fd %h, required %h %h %h %b %b %h %h",
               w, n, reg_decode, reg_intensity, reg_scan_limit, reg_shutdown, reg_test, frame_addr, frame_data,
               m_decode, m_int, m_lim, m_shut, m_test, m_addr, m_data);
    end
  endtask
  task automatic send(input logic [31:0] w, input int n);
    shift_bits(w, n);
    latch(w, n);
  endtask
  task automatic check_scan(input int nslots, input int exp_first);
    int idx, k, cnt, bad_c;
    logic [7:0] r0, er, ec, gr, gc;
    logic bad;
    k = (int'(m_int) + 1) * SD / 16;
    if (m_shut && !m_test) begin
      bad = 1'b0;
      for (int c = 0; c < 2 * SD; c++) begin
        @(posedge clk);
        #1;
        if (!bad && (row_n !== 8'hFF || col !== 8'h00)) begin bad = 1'b1; gr = row_n; gc = col; end
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL shutdown_blank: row_n/col %h/%h, required FF/00", gr, gc);
      end
      return;
    end
    @(posedge clk);
    #1;
    r0 = row_n;
    cnt = 0;
    while (row_n === r0 && cnt < 3 * SD) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    tests++;
    if (cnt >= 3 * SD) begin
      fails++;
      $display("FAIL scan_step: row_n stuck at %h for %0d cycles, required a change within %0d", r0, cnt, SD + 1);
      return;
    end
    idx = -1;
    for (int j = 0; j < 8; j++) if (~row_n == (8'b1 << j)) idx = j;
    tests++;
    if (idx < 0 || idx > int'(m_lim) || (exp_first >= 0 && idx != exp_first)) begin
      fails++;
      $display("FAIL scan_first_row: row_n %h, required one-hot row %0d (limit %0d)", row_n, exp_first, m_lim);
      return;
    end
    for (int s = 0; s < nslots; s++) begin
      bad = 1'b0;
      bad_c = 0;
      er = ~(8'b1 << idx);
      for (int c = 0; c < SD; c++) begin
        ec = m_test ? 8'hFF : (c < k ? m_digit[idx] : 8'h00);
        if (!bad && (row_n !== er || col !== ec)) begin bad = 1'b1; bad_c = c; gr = row_n; gc = col; end
        @(posedge clk);
        #1;
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL scan_slot %0d cycle %0d: row_n/col %h/%h, required %h/%h", s, bad_c, gr, gc, er,
                 m_test ? 8'hFF : (bad_c < k ? m_digit[idx] : 8'h00));
      end
      idx = (idx >= int'(m_lim)) ? 0 : idx + 1;
    end
  endtask
  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({row_n, col, reg_decode, reg_intensity, reg_scan_limit, reg_shutdown, reg_test, frame_addr, frame_data, frame_valid, frame_short} !==
        {8'hFF, 8'h00, 8'h00, 4'h0, 3'h0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: row_n %h col %h dec %h int %h lim %h sd %b tst %b fa %h fd %h v %b s %b",
               row_n, col, reg_decode, reg_intensity, reg_scan_limit, reg_shutdown, reg_test, frame_addr, frame_data,
               frame_valid, frame_short);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (frame_valid !== 1'b0 || frame_short !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_pulse: valid %b short %b, required 0 0", frame_valid, frame_short);
    end
  endtask
  task automatic test_writes();
    send(32'h0C01, 16);
    send(32'h0B07, 16);
    send(32'h0A0F, 16);
    for (int i = 1; i <= 8; i++) send({16'h0, 4'h0, 4'(i), 8'($urandom_range(1, 255))}, 16);
    check_scan(9, -1);
  endtask
  task automatic test_short();
    logic [31:0] w;
    w = $urandom;
    shift_bits(w, 12);
    latch(w, 12);
    send(32'h0381, 16);
    check_scan(8, -1);
  endtask
  task automatic test_overlong();
    send(32'h0A03, 16);
    send({12'h0, 4'($urandom), 16'h0AFF}, 20);
    send({8'h0, 8'($urandom), 16'h00AB}, 24);
  endtask
  task automatic test_display_test();
    send(32'h0C00, 16);
    check_scan(1, -1);
    send(32'h0F01, 16);
    check_scan(8, -1);
    send(32'h0F00, 16);
    check_scan(1, -1);
    send(32'h0C01, 16);
  endtask
  task automatic test_intensity();
    send(32'h0A03, 16);
    check_scan(3, -1);
    send({16'h0, 12'h0A0, 4'($urandom)}, 16);
    check_scan(2, -1);
  endtask
  task automatic test_scan_limit();
    int cnt;
    send(32'h0B07, 16);
    shift_bits(32'h0B02, 16);
    cnt = 0;
    while (row_n !== 8'hDF && cnt < 12 * SD) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    tests++;
    if (cnt >= 12 * SD) begin
      fails++;
      $display("FAIL scan_reach_row5: row_n %h, required DF within %0d cycles", row_n, 12 * SD);
    end
    latch(32'h0B02, 16);
    check_scan(4, 0);
  endtask
  task automatic test_reset_mid();
    shift_bits($urandom, 8);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if ({row_n, col, reg_decode, reg_intensity, reg_scan_limit, reg_shutdown, reg_test, frame_addr, frame_data, frame_valid, frame_short} !==
        {8'hFF, 8'h00, 8'h00, 4'h0, 3'h0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: row_n %h col %h dec %h int %h lim %h sd %b tst %b fa %h fd %h",
               row_n, col, reg_decode, reg_intensity, reg_scan_limit, reg_shutdown, reg_test, frame_addr, frame_data);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    send(32'h0A05, 16);
    send(32'h0C01, 16);
    send(32'h0B03, 16);
    send({16'h0, 8'h04, 8'($urandom_range(1, 255))}, 16);
    check_scan(5, -1);
  endtask
  task automatic test_random();
    int n;
    for (int t = 0; t < 24; t++) begin
      n = ($urandom_range(0, 4) != 0) ? 16 : ($urandom_range(0, 1) != 0 ? $urandom_range(1, 15) : $urandom_range(17, 24));
      send($urandom, n);
    end
    send({16'h0, 13'h0160, 3'($urandom_range(1, 7))}, 16);
    check_scan(4, -1);
  endtask
  initial begin
    test_reset();
    test_writes();
    test_short();
    test_overlong();
    test_display_test();
    test_intensity();
    test_scan_limit();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/max7219_rx.md
# max7219_rx

MAX7219-compatible serial responder: receives the 3-wire (serial clock, data, load) frames the dot-matrix driver emits, decodes the 16-bit register writes, and holds the MAX7219 register file. It drives an 8x8 LED matrix by scanning rows with intensity PWM. It sits on the far end of the dot-matrix serial link, either as an on-board matrix controller or as a loopback checker for the driver.

## Interface
- SCAN_DIV, 1000: clk cycles per row slot; ≥16.
- SYNC_STAGES, 2: synchronizer depth on serial inputs; ≥2.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ser_clk  in  1  serial clock from driver, asynchronous.
- ser_din  in  1  serial data, MSB (D15) first.
- ser_load  in  1  load/CS; a rising edge latches the frame.
- frame_valid  out  1  one-cycle pulse per accepted frame.
- frame_addr  out  4  D11..D8 of the last accepted frame.
- frame_data  out  8  D7..D0 of the last accepted frame.
- frame_short  out  1  one-cycle pulse when load rises with fewer than 16 bits received.
- reg_decode  out  8  decode-mode register; stored only.
- reg_intensity  out  4  intensity register.
- reg_scan_limit  out  3  scan-limit register.
- reg_shutdown  out  1  1 means shutdown.
- reg_test  out  1  display-test register bit 0.
- row_n  out  8  active-low one-hot row enable.
- col  out  8  active-high column data.

## Operation
- Reset values: digit rows 0, reg_decode 0, reg_intensity 0, reg_scan_limit 0, reg_shutdown 1, reg_test 0, frame_addr 0, frame_data 0, pulses 0, row_n 8'hFF, col 8'h00, bit count 0, scan index 0, prescaler 0.
- Front end:
  - ser_clk, ser_din and ser_load each pass through SYNC_STAGES flops.
  - Rising edges are detected on the synchronized ser_clk and ser_load.
- Shift:
  - On a ser_clk rising edge with synchronized load low, shift synchronized din into a 16-bit register (LSB in).
  - The bit count saturates at 16. Extra bits keep shifting, so the last 16 bits are retained.
  - ser_clk edges while load is high are ignored.
- Latch, on a ser_load rising edge:
  - count = 16: pulse frame_valid, update frame_addr/frame_data, and apply the write.
  - count < 16: pulse frame_short; no register change.
  - In both cases the bit count clears.
- Write decode (D15..D12 ignored):
  - 0x1–0x8: digit row 0–7.
  - 0x9: decode.
  - 0xA: intensity, D3..D0.
  - 0xB: scan limit, D2..D0.
  - 0xC: shutdown = ~D0.
  - 0xF: test = D0.
  - 0x0, 0xD, 0xE: no-op, but frame_valid still pulses.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At wrap, index = (index ≥ reg_scan_limit) ? 0 : index+1.
  - A scan-limit decrease below the current index takes effect at the next wrap (index → 0).
- Display outputs:
  - Test = 1 (overrides shutdown): row_n = ~(1<<index), col = 8'hFF.
  - Otherwise, shutdown = 1: row_n = 8'hFF, col = 0.
  - Otherwise: row_n = ~(1<<index), col = digit[index] while prescaler*16 < (reg_intensity+1)*SCAN_DIV, else col = 0.

## Timing
- ser_clk high and low phases must each be ≥ SYNC_STAGES+2 clk cycles. ser_din must be stable from the ser_clk rising edge for the same time.
- Latch latency: frame_valid, frame_addr/data and register updates occur SYNC_STAGES+1 cycles after ser_load rises at the pins, all in the same cycle.
- Simultaneous synchronized ser_clk rise and ser_load rise: the load wins and that bit is not shifted.
- row_n/col are registered and change the cycle after the prescaler wrap or register update.
- reset_n assertion mid-frame discards partial bits and returns all outputs to reset values immediately (asynchronous).

## Structure
- Package max7219_pkg:
  - address constants (ADDR_NOOP, ADDR_DIGIT0..7, ADDR_DECODE, ADDR_INTENSITY, ADDR_SCANLIM, ADDR_SHUTDOWN, ADDR_TEST);
  - register reset values;
  - frame width 16.
- Sub-module max7219_rx_shift: synchronizers, edge detection, shift register, bit counter. Outputs frame_word[15:0], load_ok and load_short pulses.
- Top level: register file, scan prescaler/index, PWM and output muxing.

## Test plan
- Reset, then write 0x0C01 (shutdown off), 0x0B07, 0x0A0F, 0x0155..0x08AA → frame_valid ×11. With SCAN_DIV = 16, row_n steps FE, FD, …, 7F each 16 cycles, and col matches the digit data for the full slot.
- Send 12 bits then raise load → frame_short pulse, frame_valid 0, registers unchanged. The next 16-bit frame 0x0381 → digit[2] = 0x81.
- Send 20 bits ending in 0x0AFF → intensity = 0xF; the leading 4 bits are dropped.
- Write 0x0F01 while shutdown = 1 → col = 0xFF on every row. Then 0x0F00 → row_n = 0xFF, col = 0.
- Intensity 0x3, SCAN_DIV = 64 → col nonzero for exactly 16 cycles per slot. Scan limit 7→2 with index at 5 → the next row is 0, then the scan cycles 0..2.
- Assert reset_n after 8 bits of a frame → outputs at reset values. A subsequent clean 16-bit frame is latched correctly.
